// File: rtl/reu_cmd_ctrl_if.sv
// Bus bundle between the REU command controller, the CPU register window
// and the DMA sequencer.
interface reu_cmd_ctrl_if;
  logic        RegSel;
  logic        RW;
  logic [3:0]  A;
  logic [7:0]  Din;
  logic [7:0]  Dout;
  logic        FF00Wr;
  logic        Execute;
  logic [1:0]  XferType;
  logic        Length1;
  logic        DMA;
  logic        XferEnd;
  logic        VerifyErr;
  logic        NextCA;
  logic        NextREUA;
  logic [15:0] CA;
  logic [18:0] REUA;
  logic        nIRQ;

  modport slave (
    input  RegSel, RW, A, Din, FF00Wr, DMA, XferEnd, VerifyErr, NextCA, NextREUA,
    output Dout, Execute, XferType, Length1, CA, REUA, nIRQ
  );

  modport master (
    output RegSel, RW, A, Din, FF00Wr, DMA, XferEnd, VerifyErr, NextCA, NextREUA,
    input  Dout, Execute, XferType, Length1, CA, REUA, nIRQ
  );
endinterface

// File: rtl/reu_cmd_ctrl.sv
// REU command controller: CPU register file, address/length counters with
// autoload shadows, transfer start FSM and interrupt status.
module reu_cmd_ctrl (
  input  logic          PHI2,
  input  logic          RESET,
  reu_cmd_ctrl_if.slave bus
);

  localparam int unsigned CA_W   = 16;
  localparam int unsigned REUA_W = 19;
  localparam int unsigned LEN_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic              cmd_exec_q, cmd_exec_d;
  logic              cmd_auto_q, cmd_auto_d;
  logic              cmd_noff_q, cmd_noff_d;
  logic [1:0]        cmd_type_q, cmd_type_d;
  logic [CA_W-1:0]   ca_q, ca_d, ca_sh_q, ca_sh_d;
  logic [REUA_W-1:0] reua_q, reua_d, reua_sh_q, reua_sh_d;
  logic [LEN_W-1:0]  len_q, len_d, len_sh_q, len_sh_d;
  logic [2:0]        mask_q, mask_d;
  logic [1:0]        actl_q, actl_d;
  logic              eob_q, eob_d;
  logic              fault_q, fault_d;

  logic reg_wr_c, cmd_wr_c, stat_rd_c, len1_c, irq_c, execute_c, done_c;
  logic [7:0] status_c, dout_c;

  // Register writes are frozen while a transfer is running.
  always_comb begin
    reg_wr_c  = bus.RegSel && !bus.RW && (state_q != S_RUN);
    cmd_wr_c  = reg_wr_c && (bus.A == 4'h1);
    stat_rd_c = bus.RegSel && bus.RW && (bus.A == 4'h0);
    len1_c    = (len_q == LEN_W'(1));
    irq_c     = mask_q[2] && ((eob_q && mask_q[1]) || (fault_q && mask_q[0]));
    status_c  = {irq_c, eob_q, fault_q, 1'b1, 4'h0};
  end

  // FSM state register
  always_ff @(negedge PHI2 or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; a command write in ARMED takes priority over FF00Wr.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_wr_c && bus.Din[7]) state_d = bus.Din[4] ? S_START : S_ARMED;
      end
      S_ARMED: begin
        if (cmd_wr_c) begin
          if (!bus.Din[7])     state_d = S_IDLE;
          else if (bus.Din[4]) state_d = S_START;
        end else if (bus.FF00Wr) begin
          state_d = S_START;
        end
      end
      S_START: if (bus.DMA)  state_d = S_RUN;
      S_RUN:   if (!bus.DMA) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    execute_c = 1'b0;
    done_c    = 1'b0;
    unique case (state_q)
      S_START: execute_c = 1'b1;
      S_DONE:  done_c    = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: counter steps, then CPU writes, then DONE housekeeping.
  always_comb begin
    cmd_exec_d = cmd_exec_q;
    cmd_auto_d = cmd_auto_q;
    cmd_noff_d = cmd_noff_q;
    cmd_type_d = cmd_type_q;
    ca_d       = ca_q;
    ca_sh_d    = ca_sh_q;
    reua_d     = reua_q;
    reua_sh_d  = reua_sh_q;
    len_d      = len_q;
    len_sh_d   = len_sh_q;
    mask_d     = mask_q;
    actl_d     = actl_q;
    eob_d      = eob_q;
    fault_d    = fault_q;

    if (bus.NextCA) begin
      if (!actl_q[1]) ca_d = ca_q + CA_W'(1);
      if (!len1_c)    len_d = len_q - LEN_W'(1);
    end
    if (bus.NextREUA && !actl_q[0]) reua_d = reua_q + REUA_W'(1);

    // Clear-on-read loses to a same-cycle set.
    if (stat_rd_c) begin
      eob_d   = 1'b0;
      fault_d = 1'b0;
    end
    if (bus.XferEnd)   eob_d   = 1'b1;
    if (bus.VerifyErr) fault_d = 1'b1;

    if (reg_wr_c) begin
      unique case (bus.A)
        4'h1: begin
          cmd_exec_d = bus.Din[7];
          cmd_auto_d = bus.Din[5];
          cmd_noff_d = bus.Din[4];
          cmd_type_d = bus.Din[1:0];
        end
        4'h2: begin ca_d[7:0]     = bus.Din; ca_sh_d[7:0]     = bus.Din; end
        4'h3: begin ca_d[15:8]    = bus.Din; ca_sh_d[15:8]    = bus.Din; end
        4'h4: begin reua_d[7:0]   = bus.Din; reua_sh_d[7:0]   = bus.Din; end
        4'h5: begin reua_d[15:8]  = bus.Din; reua_sh_d[15:8]  = bus.Din; end
        4'h6: begin reua_d[18:16] = bus.Din[2:0]; reua_sh_d[18:16] = bus.Din[2:0]; end
        4'h7: begin len_d[7:0]    = bus.Din; len_sh_d[7:0]    = bus.Din; end
        4'h8: begin len_d[15:8]   = bus.Din; len_sh_d[15:8]   = bus.Din; end
        4'h9: mask_d = bus.Din[7:5];
        4'hA: actl_d = bus.Din[7:6];
        default: ;
      endcase
    end

    if (done_c) begin
      cmd_exec_d = 1'b0;
      if (cmd_auto_q) begin
        ca_d   = ca_sh_q;
        reua_d = reua_sh_q;
        len_d  = len_sh_q;
      end
    end
  end

  // Datapath registers
  always_ff @(negedge PHI2 or posedge RESET) begin
    if (RESET) begin
      cmd_exec_q <= 1'b0;
      cmd_auto_q <= 1'b0;
      cmd_noff_q <= 1'b1;
      cmd_type_q <= 2'b00;
      ca_q       <= '0;
      ca_sh_q    <= '0;
      reua_q     <= '0;
      reua_sh_q  <= '0;
      len_q      <= '1;
      len_sh_q   <= '1;
      mask_q     <= '0;
      actl_q     <= '0;
      eob_q      <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      cmd_exec_q <= cmd_exec_d;
      cmd_auto_q <= cmd_auto_d;
      cmd_noff_q <= cmd_noff_d;
      cmd_type_q <= cmd_type_d;
      ca_q       <= ca_d;
      ca_sh_q    <= ca_sh_d;
      reua_q     <= reua_d;
      reua_sh_q  <= reua_sh_d;
      len_q      <= len_d;
      len_sh_q   <= len_sh_d;
      mask_q     <= mask_d;
      actl_q     <= actl_d;
      eob_q      <= eob_d;
      fault_q    <= fault_d;
    end
  end

  // CPU read mux; unimplemented bits read as 1.
  always_comb begin
    dout_c = 8'hFF;
    unique case (bus.A)
      4'h0: dout_c = status_c;
      4'h1: dout_c = {cmd_exec_q, 1'b1, cmd_auto_q, cmd_noff_q, 2'b11, cmd_type_q};
      4'h2: dout_c = ca_q[7:0];
      4'h3: dout_c = ca_q[15:8];
      4'h4: dout_c = reua_q[7:0];
      4'h5: dout_c = reua_q[15:8];
      4'h6: dout_c = {5'h1F, reua_q[18:16]};
      4'h7: dout_c = len_q[7:0];
      4'h8: dout_c = len_q[15:8];
      4'h9: dout_c = {mask_q, 5'h1F};
      4'hA: dout_c = {actl_q, 6'h3F};
      default: dout_c = 8'hFF;
    endcase
  end

  assign bus.Dout     = dout_c;
  assign bus.Execute  = execute_c;
  assign bus.XferType = cmd_type_q;
  assign bus.Length1  = len1_c;
  assign bus.CA       = ca_q;
  assign bus.REUA     = reua_q;
  assign bus.nIRQ     = !irq_c;

endmodule

// File: tb/tb_reu_cmd_ctrl.sv
// Directed self-checking bench for reu_cmd_ctrl.
module tb_reu_cmd_ctrl;

  logic phi2;
  logic rst;
  int   n_checks;
  int   n_errors;

  reu_cmd_ctrl_if bus ();

  reu_cmd_ctrl dut (
    .PHI2  (phi2),
    .RESET (rst),
    .bus   (bus)
  );

  initial begin
    phi2 = 1'b1;
    forever #5 phi2 = ~phi2;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One active (falling) edge, then settle 1ns.
  task automatic cyc();
    @(negedge phi2);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.RegSel = 1'b1; bus.RW = 1'b0; bus.A = a; bus.Din = d;
    cyc();
    bus.RegSel = 1'b0; bus.RW = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
    bus.RegSel = 1'b1; bus.RW = 1'b1; bus.A = a;
    #1;
    check_val(tag, 32'(bus.Dout), 32'(exp));
    cyc();
    bus.RegSel = 1'b0;
  endtask

  // Look at a register without a bus access (no clear-on-read).
  task automatic peek(input logic [3:0] a, input logic [7:0] exp, input string tag);
    bus.A = a;
    #1;
    check_val(tag, 32'(bus.Dout), 32'(exp));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.RegSel = 1'b0; bus.RW = 1'b1; bus.A = 4'h0; bus.Din = 8'h00;
    bus.FF00Wr = 1'b0; bus.DMA = 1'b0; bus.XferEnd = 1'b0; bus.VerifyErr = 1'b0;
    bus.NextCA = 1'b0; bus.NextREUA = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // Reset state
    check_val("rst_exec", 32'(bus.Execute), 32'h0);
    check_val("rst_ca", 32'(bus.CA), 32'h0);
    check_val("rst_reua", 32'(bus.REUA), 32'h0);
    check_val("rst_nirq", 32'(bus.nIRQ), 32'h1);
    check_val("rst_len1", 32'(bus.Length1), 32'h0);
    check_val("rst_xtype", 32'(bus.XferType), 32'h0);
    peek(4'h0, 8'h10, "rst_status");
    peek(4'h1, 8'h5C, "rst_cmd");
    peek(4'h6, 8'hF8, "rst_bank");
    peek(4'h7, 8'hFF, "rst_len_lo");
    peek(4'h8, 8'hFF, "rst_len_hi");
    peek(4'h9, 8'h1F, "rst_mask");
    peek(4'hA, 8'h3F, "rst_actl");
    peek(4'hC, 8'hFF, "rst_unused");

    // Basic C64->REU transfer of 3 bytes, no FF00 wait
    wr(4'h7, 8'h03); wr(4'h8, 8'h00); wr(4'h2, 8'h34); wr(4'h3, 8'h12);
    check_val("ca_load", 32'(bus.CA), 32'h1234);
    wr(4'h1, 8'h90);
    check_val("exec_start", 32'(bus.Execute), 32'h1);
    bus.DMA = 1'b1; cyc();
    check_val("exec_run", 32'(bus.Execute), 32'h0);
    wr(4'h2, 8'hAA);
    check_val("run_wr_ignored", 32'(bus.CA), 32'h1234);
    bus.NextCA = 1'b1; cyc();
    check_val("step1_ca", 32'(bus.CA), 32'h1235);
    check_val("step1_len1", 32'(bus.Length1), 32'h0);
    cyc();
    check_val("step2_len1", 32'(bus.Length1), 32'h1);
    bus.XferEnd = 1'b1; cyc();
    bus.NextCA = 1'b0; bus.XferEnd = 1'b0;
    check_val("step3_ca", 32'(bus.CA), 32'h1237);
    check_val("step3_len1", 32'(bus.Length1), 32'h1);
    bus.DMA = 1'b0; cyc(); cyc();
    peek(4'h1, 8'h5C, "done_cmd");
    peek(4'h7, 8'h01, "done_len");
    peek(4'h0, 8'h50, "eob_status");
    check_val("eob_nirq", 32'(bus.nIRQ), 32'h1);
    rd(4'h0, 8'h50, "eob_rd");
    peek(4'h0, 8'h10, "eob_cleared");

    // FF00-triggered start
    wr(4'h1, 8'h81);
    check_val("armed_exec", 32'(bus.Execute), 32'h0);
    check_val("armed_xtype", 32'(bus.XferType), 32'h1);
    cyc();
    check_val("armed_hold", 32'(bus.Execute), 32'h0);
    bus.FF00Wr = 1'b1; cyc(); bus.FF00Wr = 1'b0;
    check_val("ff00_exec", 32'(bus.Execute), 32'h1);
    bus.DMA = 1'b1; cyc(); bus.DMA = 1'b0; cyc(); cyc();
    peek(4'h1, 8'h4D, "ff00_cmd_done");

    // Command write beats same-cycle FF00Wr in ARMED
    wr(4'h1, 8'h81);
    bus.FF00Wr = 1'b1; wr(4'h1, 8'h01); bus.FF00Wr = 1'b0;
    check_val("abort_exec", 32'(bus.Execute), 32'h0);
    cyc();
    check_val("abort_idle", 32'(bus.Execute), 32'h0);

    // Autoload restores CA and length
    wr(4'h2, 8'h00); wr(4'h3, 8'hC0); wr(4'h7, 8'h02); wr(4'h8, 8'h00);
    wr(4'h1, 8'hB0);
    bus.DMA = 1'b1; cyc();
    bus.NextCA = 1'b1; cyc(); cyc(); bus.NextCA = 1'b0;
    check_val("auto_ca_mid", 32'(bus.CA), 32'hC002);
    bus.DMA = 1'b0; cyc(); cyc();
    check_val("auto_ca", 32'(bus.CA), 32'hC000);
    peek(4'h7, 8'h02, "auto_len");
    check_val("auto_len1", 32'(bus.Length1), 32'h0);
    peek(4'h1, 8'h7C, "auto_cmd");

    // Verify error raises interrupt
    wr(4'h9, 8'hA0);
    peek(4'h9, 8'hBF, "mask_rd");
    wr(4'h1, 8'h93);
    bus.DMA = 1'b1; cyc();
    bus.VerifyErr = 1'b1; cyc(); bus.VerifyErr = 1'b0;
    peek(4'h0, 8'hB0, "verr_status");
    check_val("verr_nirq", 32'(bus.nIRQ), 32'h0);
    bus.DMA = 1'b0; cyc(); cyc();
    bus.VerifyErr = 1'b1;
    rd(4'h0, 8'hB0, "setwins_rd");
    bus.VerifyErr = 1'b0;
    peek(4'h0, 8'hB0, "setwins_status");
    rd(4'h0, 8'hB0, "verr_rd");
    peek(4'h0, 8'h10, "verr_cleared");
    check_val("verr_nirq_clr", 32'(bus.nIRQ), 32'h1);

    // Fixed addresses with address control $C0
    wr(4'hA, 8'hC0);
    peek(4'hA, 8'hFF, "actl_rd");
    wr(4'h2, 8'h00); wr(4'h3, 8'h10);
    wr(4'h4, 8'h10); wr(4'h5, 8'h20); wr(4'h6, 8'h03);
    wr(4'h7, 8'h04); wr(4'h8, 8'h00);
    wr(4'h1, 8'h90);
    bus.DMA = 1'b1; cyc();
    bus.NextCA = 1'b1; bus.NextREUA = 1'b1;
    repeat (4) cyc();
    bus.NextCA = 1'b0; bus.NextREUA = 1'b0;
    check_val("fix_ca", 32'(bus.CA), 32'h1000);
    check_val("fix_reua", 32'(bus.REUA), 32'h32010);
    check_val("fix_len1", 32'(bus.Length1), 32'h1);
    bus.DMA = 1'b0; cyc(); cyc();

    // Counter wrap boundaries
    wr(4'hA, 8'h00);
    wr(4'h4, 8'hFF); wr(4'h5, 8'hFF); wr(4'h6, 8'h07);
    check_val("reua_max", 32'(bus.REUA), 32'h7FFFF);
    peek(4'h6, 8'hFF, "bank_max");
    bus.NextREUA = 1'b1; cyc(); bus.NextREUA = 1'b0;
    check_val("reua_wrap", 32'(bus.REUA), 32'h0);
    wr(4'h2, 8'hFF); wr(4'h3, 8'hFF); wr(4'h7, 8'h00); wr(4'h8, 8'h00);
    bus.NextCA = 1'b1; cyc(); bus.NextCA = 1'b0;
    check_val("ca_wrap", 32'(bus.CA), 32'h0);
    peek(4'h8, 8'hFF, "len0_wrap");

    // Reset during RUN
    wr(4'h2, 8'h55); wr(4'h7, 8'h05);
    wr(4'h1, 8'h90);
    bus.DMA = 1'b1; cyc();
    rst = 1'b1; #1;
    check_val("rrst_exec", 32'(bus.Execute), 32'h0);
    check_val("rrst_ca", 32'(bus.CA), 32'h0);
    peek(4'h1, 8'h5C, "rrst_cmd");
    peek(4'h7, 8'hFF, "rrst_len_lo");
    peek(4'h8, 8'hFF, "rrst_len_hi");
    check_val("rrst_nirq", 32'(bus.nIRQ), 32'h1);
    cyc();
    rst = 1'b0; bus.DMA = 1'b0;
    cyc();
    check_val("rrst_idle", 32'(bus.Execute), 32'h0);
    wr(4'h1, 8'h90);
    check_val("rrst_restart", 32'(bus.Execute), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
